// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and bulk-clear signals of the multi-port register file
// Ports (via modports):
//   master drives ra, wa3, wd3, we3, clr_req and receives rd, clr_busy, clr_done
//   slave  is the register file side, with the directions reversed
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREG);
    logic [NREAD*AW-1:0]   ra;
    logic [NREAD*XLEN-1:0] rd;
    logic [AW-1:0]         wa3;
    logic [XLEN-1:0]       wd3;
    logic                  we3;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  clr_done;
    modport master (output ra, wa3, wd3, we3, clr_req, input rd, clr_busy, clr_done);
    modport slave  (input ra, wa3, wd3, we3, clr_req, output rd, clr_busy, clr_done);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with hardwired-zero entry 0 and a sequential bulk clear
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; zeroes every entry and idles the clear engine
//   bus  regfile_mp_if.slave:
//        ra/rd             NREAD combinational read ports, flattened
//        wa3/wd3/we3       synchronous write port
//        clr_req           starts a sweep that zeroes entries 1..NREG-1, one per cycle
//        clr_busy/clr_done busy during the sweep, then a one-cycle done pulse
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NREAD = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREG);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    state_t                    state, state_n;
    logic [AW-1:0]             idx;
    logic                      busy, done, wr;
    logic [NREG-1:0][XLEN-1:0] view;

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        state_n = (state == IDLE)  ? (bus.clr_req ? SWEEP : IDLE) :
                  (state == SWEEP) ? ((idx == AW'(NREG-1)) ? DONE : SWEEP) : IDLE;
        busy    = state == SWEEP;
        done    = state == DONE;
    end

    // idx is preloaded with 1 outside the sweep so entry 1 is cleared on the first sweep edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= (state == SWEEP) ? idx + 1'b1 : AW'(1);
        end

    assign bus.clr_busy = busy;
    assign bus.clr_done = done;
    // rst gates the write so that forwarding cannot leak data while the file is held in reset
    assign wr   = bus.we3 && (bus.wa3 != '0) && !busy && !rst;
    assign view[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [XLEN-1:0] q;
        always_ff @(posedge clk or posedge rst)
            if (rst)
                q <= '0;
            else if (busy && idx == AW'(r))
                q <= '0;
            else if (wr && bus.wa3 == AW'(r))
                q <= bus.wd3;
        assign view[r] = q;
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = bus.ra[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign bus.rd[i*XLEN +: XLEN] = (wr && a == bus.wa3) ? bus.wd3 : view[a];
`else
        assign bus.rd[i*XLEN +: XLEN] = view[a];
`endif
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (NREG=32, NREAD=4) against an array model
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ntests = 0;
    int   nfail  = 0;
    logic [31:0]      mdl [32];
    logic [3:0][4:0]  ra_v;

    regfile_mp_if #(.XLEN(32), .NREG(32), .NREAD(4)) bus ();
    regfile_mp #(.XLEN(32), .NREG(32), .NREAD(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic             we;
        logic [4:0]       wa;
        logic [31:0]      wd;
        logic [3:0][4:0]  ra;
        logic [3:0][31:0] ex;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] port(input int p);
        return bus.rd[p*32 +: 32];
    endfunction

    function automatic logic [31:0] fv(input int r);
        return 32'h1000_0000 + 32'(r) * 32'h111;
    endfunction

    // reference read: entry 0 is zero, otherwise the stored value (or the pending write when forwarding)
    function automatic logic [31:0] mref(input int a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (bus.we3 && int'(bus.wa3) == a) return bus.wd3;
`endif
        return mdl[a];
    endfunction

    task automatic rdchk(input string name);
        for (int p = 0; p < 4; p++) chk(name, port(p), mref(int'(ra_v[p])));
    endtask

    task automatic allzero(input string name);
        bus.we3 = 1'b0;
        for (int r = 0; r < 32; r++) begin
            ra_v = '0;
            ra_v[0] = 5'(r);
            bus.ra = ra_v;
            #1;
            chk(name, port(0), 32'h0);
        end
    endtask

    task automatic fill();
        ra_v = '0;
        bus.ra = ra_v;
        for (int r = 1; r < 32; r++) begin
            bus.we3 = 1'b1;
            bus.wa3 = 5'(r);
            bus.wd3 = fv(r);
            @(posedge clk);
            mdl[r] = fv(r);
            @(negedge clk);
        end
        bus.we3 = 1'b0;
    endtask

    initial begin
        int n, busy_cnt;
        for (int r = 0; r < 32; r++) mdl[r] = 32'h0;
        ra_v = '0;
        bus.ra = ra_v;
        bus.we3 = 1'b0;
        bus.wa3 = '0;
        bus.wd3 = '0;
        bus.clr_req = 1'b0;

        tbl[0] = '{1'b1, 5'd1,  32'hAAAABBBB, {5'd0, 5'd0, 5'd0, 5'd1},
                   {32'h0, 32'h0, 32'h0, 32'hAAAABBBB}};
        tbl[1] = '{1'b1, 5'd0,  32'hDEADBEEF, {5'd0, 5'd0, 5'd0, 5'd0},
                   {32'h0, 32'h0, 32'h0, 32'h0}};
        tbl[2] = '{1'b1, 5'd2,  32'h12345678, {5'd0, 5'd0, 5'd1, 5'd2},
                   {32'h0, 32'h0, 32'hAAAABBBB, 32'h12345678}};
        tbl[3] = '{1'b1, 5'd5,  32'hDEADBEEF, {5'd5, 5'd1, 5'd2, 5'd5},
                   {32'hDEADBEEF, 32'hAAAABBBB, 32'h12345678, 32'hDEADBEEF}};
        tbl[4] = '{1'b0, 5'd5,  32'h0,        {5'd0, 5'd0, 5'd0, 5'd5},
                   {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}};
        tbl[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, {5'd2, 5'd0, 5'd5, 5'd31},
                   {32'h12345678, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF}};
        tbl[6] = '{1'b1, 5'd1,  32'h00000001, {5'd1, 5'd1, 5'd1, 5'd1},
                   {32'h1, 32'h1, 32'h1, 32'h1}};

        // reset held for two cycles
        #1;
        rdchk("reset_rd_t1");
        repeat (2) @(negedge clk);
        rdchk("reset_rd");
        chk("reset_busy", 32'(bus.clr_busy), 32'h0);
        chk("reset_done", 32'(bus.clr_done), 32'h0);
        rst = 1'b0;
        #1;
        rdchk("post_reset_rd");

        // directed table: pre-edge against the model, post-edge against table constants
        for (int v = 0; v < 7; v++) begin
            bus.we3 = tbl[v].we;
            bus.wa3 = tbl[v].wa;
            bus.wd3 = tbl[v].wd;
            ra_v    = tbl[v].ra;
            bus.ra  = ra_v;
            #1;
            rdchk($sformatf("tbl%0d_pre", v));
            @(posedge clk);
            if (tbl[v].we && tbl[v].wa != 0) mdl[tbl[v].wa] = tbl[v].wd;
            @(negedge clk);
            for (int p = 0; p < 4; p++) chk($sformatf("tbl%0d_post_p%0d", v, p), port(p), tbl[v].ex[p]);
        end

        // randomized writes and reads
        for (int k = 0; k < 300; k++) begin
            bus.we3 = 1'($urandom_range(0, 1));
            bus.wa3 = 5'($urandom_range(0, 31));
            bus.wd3 = $urandom;
            for (int p = 0; p < 4; p++) ra_v[p] = 5'($urandom_range(0, 31));
            bus.ra = ra_v;
            #1;
            rdchk("rand");
            @(posedge clk);
            if (bus.we3 && bus.wa3 != 0) mdl[bus.wa3] = bus.wd3;
            @(negedge clk);
        end
        bus.we3 = 1'b0;

        // bulk clear with a dropped write and an ignored second request
        fill();
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (bus.clr_busy && n < 100) begin
            busy_cnt++;
            chk("sweep_done_low", 32'(bus.clr_done), 32'h0);
            ra_v = '0;
            ra_v[0] = 5'(n - 1);
            ra_v[1] = 5'(n);
            bus.ra = ra_v;
            #1;
            chk("sweep_cleared", port(0), 32'h0);
            if (n < 32) chk("sweep_pending", port(1), fv(n));
            bus.we3 = (n == 10);
            bus.wa3 = 5'd7;
            bus.wd3 = 32'h7777_7777;
            bus.clr_req = (n == 12);
            @(negedge clk);
            n++;
        end
        bus.we3 = 1'b0;
        bus.clr_req = 1'b0;
        chk("sweep_busy_cycles", 32'(busy_cnt), 32'd31);
        chk("sweep_done_pulse", 32'(bus.clr_done), 32'h1);
        for (int r = 1; r < 32; r++) mdl[r] = 32'h0;
        // first write accepted during the done cycle
        bus.we3 = 1'b1;
        bus.wa3 = 5'd3;
        bus.wd3 = 32'h0000_0033;
        @(negedge clk);
        bus.we3 = 1'b0;
        chk("done_one_cycle", 32'(bus.clr_done), 32'h0);
        chk("busy_not_extended", 32'(bus.clr_busy), 32'h0);
        ra_v = '0;
        ra_v[0] = 5'd3;
        ra_v[1] = 5'd7;
        bus.ra = ra_v;
        #1;
        chk("write_in_done", port(0), 32'h0000_0033);
        chk("dropped_write_r7", port(1), 32'h0);
        mdl[3] = 32'h0000_0033;
        for (int r = 1; r < 32; r++) begin
            ra_v = '0;
            ra_v[0] = 5'(r);
            bus.ra = ra_v;
            #1;
            chk("after_clear", port(0), mdl[r]);
        end

        // reset ten cycles into a sweep
        @(negedge clk);
        fill();
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        n = 0;
        while (bus.clr_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_sweep_reached", 32'(n), 32'd10);
        chk("mid_sweep_busy", 32'(bus.clr_busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy_async", 32'(bus.clr_busy), 32'h0);
        ra_v = '0;
        ra_v[0] = 5'd31;
        bus.ra = ra_v;
        #1;
        chk("rst_async_rd", port(0), 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            chk("rst_no_done", 32'(bus.clr_done), 32'h0);
            chk("rst_no_busy", 32'(bus.clr_busy), 32'h0);
        end
        for (int r = 1; r < 32; r++) mdl[r] = 32'h0;
        allzero("after_rst_sweep");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file, the successor to the fixed 32x32 two-read/one-write register file in the single-cycle RV32 core. Provides NREAD combinational read ports, one synchronous write port, a hardwired-zero register 0, asynchronous reset to zero, and a sequential bulk-clear engine that zeroes the file one entry per cycle. Sits in the decode stage between instruction decode (read addresses) and writeback (write port).

## Interface

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, ≥ 4.
- NREAD, 2, number of read ports; ≥ 1.
- Localparam AW = $clog2(NREG), address width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ra  in  NREAD*AW  read addresses, flattened; port i uses ra[i*AW +: AW].
- rd  out  NREAD*XLEN  read data, flattened; port i uses rd[i*XLEN +: XLEN].
- wa3  in  AW  write address.
- wd3  in  XLEN  write data.
- we3  in  1  write enable.
- clr_req  in  1  request to start a bulk clear; sampled on the rising edge.
- clr_busy  out  1  high while the clear sweep is in progress.
- clr_done  out  1  single-cycle pulse when the sweep completes.

## Operation

- Storage: NREG × XLEN. Entry 0 is not stored. It always reads 0, and writes to it are discarded.
- Read: rd[i] = regs[ra[i]] combinationally. All NREAD ports are independent. Identical addresses on several ports are legal.
- Write: on a rising edge with we3=1, wa3≠0 and clr_busy=0, regs[wa3] ← wd3.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP when clr_req=1 at an edge. The index counter is loaded with 1.
  - SWEEP: each edge writes regs[idx] ← 0 and then increments idx. After clearing entry NREG-1, the FSM moves to DONE.
  - DONE: clr_done=1 for one cycle, then IDLE.
  - clr_busy=1 in SWEEP only.
- Write while clr_busy=1: the user write is dropped silently and has no effect on the final state.
- clr_req while in SWEEP or DONE is ignored; it is not queued.
- Reads during SWEEP return the current contents. An entry shows 0 once its clearing edge has passed.
- Index counter is AW bits wide. The terminal compare is against NREG-1, so there is no wrap-around.

## Timing

- Reset (rst=1, asynchronous):
  - All entries become 0 and the FSM goes to IDLE.
  - clr_busy=0 and clr_done=0.
  - rd reads 0 for every address while rst=1 and after release.
- Reset mid-sweep aborts the sweep immediately. No clr_done pulse is produced.
- Read latency is 0 cycles (combinational). Write-to-read latency is 1 edge without bypass.
- Clear: clr_req sampled at edge E.
  - clr_busy is high from E to E+NREG-1; the last entry is cleared at edge E+NREG-1.
  - clr_done is high from E+NREG-1 to E+NREG.
  - For NREG=32: 31 busy cycles, then a 1-cycle done pulse.
- The first user write is accepted at the edge after clr_busy falls, i.e. during the DONE cycle.

## Configuration

- REGFILE_BYPASS_EN defined:
  - Write-to-read forwarding is active. If we3=1, wa3≠0, clr_busy=0 and ra[i]==wa3, then rd[i]=wd3 combinationally in the same cycle.
  - Forwarding is applied per port independently.
- REGFILE_BYPASS_EN undefined:
  - rd[i] returns the stored value only. The new value appears after the write edge.
- Entry 0 and clear-busy suppression are identical in both builds.

## Test plan

- Reset: assert rst for 2 cycles at any time → rd all 0, clr_busy=0, clr_done=0. Entries written before reset read 0 afterwards.
- Write/read: we3=1, wa3=1, wd3=0xAAAABBBB; ra port0=1, port1=0.
  - Without bypass: port0=0 before the edge and 0xAAAABBBB after it.
  - With bypass: port0=0xAAAABBBB 1 ns after wd3 is driven.
  - port1 stays 0 in both builds.
- Register 0: we3=1, wa3=0, wd3=0xDEADBEEF → all ports addressing 0 read 0, before and after the edge, in both builds.
- Multi-port (NREAD=4): write regs 1, 2, 5 with 0xAAAABBBB, 0x12345678, 0xDEADBEEF; ra={5,2,1,5} → rd={0xDEADBEEF, 0x12345678, 0xAAAABBBB, 0xDEADBEEF}.
- Bulk clear (NREG=32): fill regs 1..31 with nonzero values, pulse clr_req for 1 cycle.
  - clr_busy high for 31 cycles, then clr_done high for 1 cycle.
  - All entries read 0 afterwards.
  - A write to reg 7 issued mid-sweep is dropped, so reg 7 reads 0.
  - A second clr_req mid-sweep does not extend busy.
- Reset mid-sweep: assert rst 10 cycles into the sweep → clr_busy drops asynchronously, no clr_done pulse, all entries read 0.
